// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, two half-adders plus carry flop, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb, rs;
  logic c;
  logic [CW-1:0] cnt;
  logic p, g1, s, g2, cn, last;
  always_comb begin
    p = ra[0] ^ rb[0];
    g1 = ra[0] & rb[0];
    s = p ^ c;
    g2 = p & c;
    cn = g1 | g2;
    last = cnt == CW'(WIDTH - 1);
    state_n = state;
    case (state)
      IDLE:    state_n = start ? SHIFT : IDLE;
      SHIFT:   state_n = last ? DONE : SHIFT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra <= '0;
      rb <= '0;
      rs <= '0;
      c <= 1'b0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sum_out <= '0;
      cout <= 1'b0;
    end else begin
      state <= state_n;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ra <= a_in;
          rb <= b_in;
          c <= cin;
          cnt <= '0;
          busy <= 1'b1;
        end
        SHIFT: begin
          ra <= ra >> 1;
          rb <= rb >> 1;
          rs <= {s, rs[WIDTH-1:1]};
          c <= cn;
          cnt <= cnt + 1'b1;
          if (last) begin
            sum_out <= {s, rs[WIDTH-1:1]};
            cout <= cn;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder against a plain-arithmetic reference
module tb_serial_adder;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic busy, done, cout;
  logic [W-1:0] sum_out;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    int           acc;
  } exp_t;

  exp_t q[$];
  int cyc = 0, next_ok = 0, n_chk = 0, n_fail = 0;
  logic [W-1:0] held = '0;
  logic heldc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Acceptance model: an adder is idle WIDTH+2 edges after it accepted, or one edge after reset
  always @(posedge clk) begin
    if (rst) next_ok = cyc + 2;
    else if (start && cyc + 1 >= next_ok) begin
      logic [W:0] t;
      t = {1'b0, a_in} + {1'b0, b_in} + (W+1)'(cin);
      q.push_back(exp_t'{t[W-1:0], t[W], cyc + 1});
      next_ok = cyc + 1 + W + 2;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum_out, 0);
      chk("rst_cout", cout, 0);
      q.delete();
      held = '0;
      heldc = 1'b0;
    end else begin
      bit de, be;
      de = q.size() > 0 && cyc == q[0].acc + W;
      be = q.size() > 0 && cyc >= q[0].acc && cyc < q[0].acc + W;
      chk("done", done, de);
      chk("busy", busy, be);
      if (de) begin
        chk("sum", sum_out, q[0].s);
        chk("cout", cout, q[0].co);
        held = q[0].s;
        heldc = q[0].co;
        void'(q.pop_front());
      end else begin
        chk("hold_sum", sum_out, held);
        chk("hold_cout", cout, heldc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input int gap);
    @(negedge clk);
    a_in = a; b_in = b; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
    idle(gap);
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    idle(5);
    op(8'h3C, 8'h0F, 1'b0, W + 2);
    op(8'hFF, 8'h01, 1'b0, W + 2);
    op(8'h5A, 8'hA5, 1'b1, W + 2);
    op(8'h10, 8'h20, 1'b0, 2);
    a_in = 8'hFF; b_in = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(W + 2);
    a_in = 8'h01; b_in = 8'h01; cin = 1'b0; start = 1'b1;
    idle(35);
    start = 1'b0;
    idle(12);
    op(8'hAA, 8'h55, 1'b0, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    op(8'h01, 8'h02, 1'b0, W + 2);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom % 3) == 0;
      a_in = W'($urandom);
      b_in = W'($urandom);
      cin = 1'($urandom);
      rst = ($urandom % 150) == 0;
    end
    rst = 1'b0;
    start = 1'b0;
    idle(15);
    chk("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
